// File: rtl/plusarg_watchdog.sv
// Idle-cycle watchdog fed by a plusarg-supplied 32-bit budget; limit 0 disables it.
// Optional half-budget warn output is built only when WATCHDOG_WARN_EN is defined.
module plusarg_watchdog (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] limit,
   input  logic        enable,
   input  logic        kick,
   input  logic        clear,
   output logic        active,
   output logic        expired,
   output logic [31:0] count
`ifdef WATCHDOG_WARN_EN
   ,
   output logic        warn
`endif
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARMED   = 2'd1;
   localparam logic [1:0] ST_EXPIRED = 2'd2;

   logic [1:0]  r_state;
   logic [31:0] r_count;
   logic [31:0] r_lim;
   logic [31:0] w_count_inc;
   logic        w_hit;

   // In ARMED the count is always below r_lim, so the increment cannot wrap.
   assign w_count_inc = r_count + 32'd1;
   assign w_hit       = (w_count_inc == r_lim);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_count <= 32'd0;
         r_lim   <= 32'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_count <= 32'd0;
               if (enable && (limit != 32'd0)) begin
                  r_state <= ST_ARMED;
                  r_lim   <= limit;
               end
            end
            ST_ARMED: begin
               if (!enable) begin
                  r_state <= ST_IDLE;
                  r_count <= 32'd0;
               end else if (kick) begin
                  r_count <= 32'd0;
               end else if (w_hit) begin
                  r_state <= ST_EXPIRED;
                  r_count <= r_lim;
               end else begin
                  r_count <= w_count_inc;
               end
            end
            ST_EXPIRED: begin
               // Sticky: only clear leaves; kick and enable are ignored here.
               if (clear) begin
                  r_state <= ST_IDLE;
                  r_count <= 32'd0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_count <= 32'd0;
            end
         endcase
      end
   end

   assign active  = (r_state == ST_ARMED);
   assign expired = (r_state == ST_EXPIRED);
   assign count   = r_count;

`ifdef WATCHDOG_WARN_EN
   logic [32:0] w_half;

   // 33-bit sum keeps a 0xFFFF_FFFF budget from wrapping the threshold.
   assign w_half = ({1'b0, r_lim} + 33'd1) >> 1;
   assign warn   = (r_state == ST_ARMED) && ({1'b0, r_count} >= w_half);
`endif

endmodule

// File: tb/tb_plusarg_watchdog.sv
// Directed bench for plusarg_watchdog: zero-limit disable, expiry, kick race,
// sticky/clear, mid-run reset, limit=1 and (with WATCHDOG_WARN_EN) warn.
module tb_plusarg_watchdog;

   logic        clock;
   logic        reset;
   logic [31:0] limit;
   logic        enable;
   logic        kick;
   logic        clear;
   logic        active;
   logic        expired;
   logic [31:0] count;
`ifdef WATCHDOG_WARN_EN
   logic        warn;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   plusarg_watchdog dut (
      .clock   (clock),
      .reset   (reset),
      .limit   (limit),
      .enable  (enable),
      .kick    (kick),
      .clear   (clear),
      .active  (active),
      .expired (expired),
`ifdef WATCHDOG_WARN_EN
      .warn    (warn),
`endif
      .count   (count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one rising edge and settle 1 ns past it before sampling or driving.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic a, input logic e, input logic [31:0] c);
      check({tag, ".active"},  {31'd0, active},  {31'd0, a});
      check({tag, ".expired"}, {31'd0, expired}, {31'd0, e});
      check({tag, ".count"},   count, c);
   endtask

   initial begin
      reset  = 1'b1;
      limit  = 32'd0;
      enable = 1'b0;
      kick   = 1'b0;
      clear  = 1'b0;
      tick();
      tick();
      check_out("reset", 1'b0, 1'b0, 32'd0);

      // Zero limit keeps the watchdog asleep even with enable high.
      reset  = 1'b0;
      enable = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if ((i % 100) == 99) check_out("zero_limit", 1'b0, 1'b0, 32'd0);
      end

      // Basic expiry with limit 5.
      enable = 1'b0;
      limit  = 32'd5;
      tick();
      check_out("idle_before_arm", 1'b0, 1'b0, 32'd0);
      enable = 1'b1;
      tick();
      check_out("arm_edge", 1'b1, 1'b0, 32'd0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         check_out("basic_count", 1'b1, 1'b0, 32'(i));
      end
      tick();
      check_out("basic_expire", 1'b0, 1'b1, 32'd5);

      // Sticky: kick and disable do not release expiry.
      kick   = 1'b1;
      enable = 1'b0;
      tick();
      tick();
      check_out("sticky", 1'b0, 1'b1, 32'd5);
      kick   = 1'b0;

      // Clear with enable high: one IDLE cycle, re-arm, expire 5 edges later.
      enable = 1'b1;
      clear  = 1'b1;
      tick();
      check_out("clear_idle", 1'b0, 1'b0, 32'd0);
      clear  = 1'b0;
      tick();
      check_out("rearm", 1'b1, 1'b0, 32'd0);
      for (int i = 0; i < 4; i++) tick();
      check_out("rearm_count4", 1'b1, 1'b0, 32'd4);
      tick();
      check_out("rearm_expire", 1'b0, 1'b1, 32'd5);

      // Return to IDLE, then arm for the kick race.
      enable = 1'b0;
      clear  = 1'b1;
      tick();
      clear  = 1'b0;
      enable = 1'b1;
      tick();
      check_out("race_arm", 1'b1, 1'b0, 32'd0);
      for (int i = 0; i < 200; i++) begin
         kick = ((i % 5) == 4);
         if (i == 50) limit = 32'd2;
         tick();
         if ((i % 5) == 4) check_out("race_kick", 1'b1, 1'b0, 32'd0);
         else if ((i % 20) == 3) check_out("race_count", 1'b1, 1'b0, 32'((i % 5) + 1));
      end
      kick = 1'b0;

      // Reset mid-run at count 3; re-arm latches the new limit of 2.
      tick();
      tick();
      tick();
      check_out("pre_reset", 1'b1, 1'b0, 32'd3);
      reset = 1'b1;
      tick();
      check_out("mid_reset", 1'b0, 1'b0, 32'd0);
      reset = 1'b0;
      tick();
      check_out("post_reset_arm", 1'b1, 1'b0, 32'd0);
      tick();
      check_out("lim2_count1", 1'b1, 1'b0, 32'd1);
      tick();
      check_out("lim2_expire", 1'b0, 1'b1, 32'd2);

      // Limit 1: expires on the first edge unless a kick is sampled there.
      enable = 1'b0;
      clear  = 1'b1;
      tick();
      clear  = 1'b0;
      limit  = 32'd1;
      enable = 1'b1;
      tick();
      check_out("lim1_arm", 1'b1, 1'b0, 32'd0);
      tick();
      check_out("lim1_expire", 1'b0, 1'b1, 32'd1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      tick();
      check_out("lim1_rearm", 1'b1, 1'b0, 32'd0);
      kick = 1'b1;
      tick();
      check_out("lim1_kick_wins", 1'b1, 1'b0, 32'd0);
      kick = 1'b0;

      // Full-range limit: disable drops to IDLE, arm and count up.
      enable = 1'b0;
      tick();
      check_out("disable_idle", 1'b0, 1'b0, 32'd0);
      limit  = 32'hFFFF_FFFF;
      enable = 1'b1;
      tick();
      tick();
      tick();
      check_out("max_limit", 1'b1, 1'b0, 32'd2);

`ifdef WATCHDOG_WARN_EN
      enable = 1'b0;
      tick();
      limit  = 32'd6;
      enable = 1'b1;
      tick();
      check("warn_arm", {31'd0, warn}, 32'd0);
      tick();
      tick();
      check("warn_count2", {31'd0, warn}, 32'd0);
      tick();
      check("warn_count3", {31'd0, warn}, 32'd1);
      kick = 1'b1;
      tick();
      kick = 1'b0;
      check("warn_kick", {31'd0, warn}, 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
